bsg_gear_collector: RTL and testbench

- Upstream feeder for the gear combinator stage.
- Collects narrow elements from two independent lanes (lane 0 carries even-indexed elements, lane 1 carries odd-indexed elements) into two els_p-wide words.
- Presents both words together on a single valid/yumi interface, so the downstream combinator can cross-splice them into sequential order.
- Each lane fills independently; a word pair is released only when both lanes are full.

---
 rtl/bsg_gear_collector.sv | 122 ++++++++++++
 tb/tb_bsg_gear_collector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_gear_collector.sv
// Two-lane element collector: lane 0 fills the even-slot word, lane 1 the odd-slot word; the pair is offered together.
// Optional macro BSG_GEAR_COLLECTOR_FLOWTHRU_EN lets a lane refill in the same cycle its full word is taken.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_gear_collector #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v0_i,
    input  logic [width_p-1:0]         data0_i,
    output logic                       ready0_o,
    input  logic                       v1_i,
    input  logic [width_p-1:0]         data1_i,
    output logic                       ready1_o,
    output logic                       v_o,
    output logic [width_p*els_p-1:0]   data0_o,
    output logic [width_p*els_p-1:0]   data1_o,
    input  logic                       yumi_i
);

    localparam int lg_els_lp = `BSG_SAFE_CLOG2(els_p+1);
    localparam logic [lg_els_lp-1:0] els_lp = lg_els_lp'(els_p);

    if ((els_p != 1) && ((els_p % 2) != 0)) begin : g_bad_els
        $error("bsg_gear_collector: els_p must be 1 or even");
    end

    logic                 ready_en_q;
    logic [lg_els_lp-1:0] count_q [2];
    logic [lg_els_lp-1:0] count_d [2];
    logic [lg_els_lp-1:0] wr_idx  [2];
    logic [width_p-1:0]   slot_q  [2][els_p];
    logic [width_p-1:0]   lane_data [2];
    logic [1:0]           lane_v;
    logic [1:0]           full;
    logic [1:0]           ready;
    logic [1:0]           accept;
    logic                 drain;

    assign lane_v       = {v1_i, v0_i};
    assign lane_data[0] = data0_i;
    assign lane_data[1] = data1_i;

    assign full[0] = (count_q[0] == els_lp);
    assign full[1] = (count_q[1] == els_lp);

    // v_o comes only from the counters, so nothing on v*_i can reach it.
    assign v_o   = full[0] & full[1];
    assign drain = yumi_i & v_o;

    assign ready0_o = ready[0];
    assign ready1_o = ready[1];

    always_comb begin
        ready  = '0;
        accept = '0;
        for (int k = 0; k < 2; k++) begin
            wr_idx[k]  = '0;
            count_d[k] = count_q[k];
        end
        for (int k = 0; k < 2; k++) begin
`ifdef BSG_GEAR_COLLECTOR_FLOWTHRU_EN
            ready[k] = ready_en_q & (~full[k] | drain);
`else
            ready[k] = ready_en_q & ~full[k];
`endif
            accept[k] = lane_v[k] & ready[k];
            // A drain restarts the lane, so a same-cycle accept lands in slot 0.
            wr_idx[k]  = drain ? '0 : count_q[k];
            count_d[k] = drain ? lg_els_lp'(accept[k])
                               : count_q[k] + lg_els_lp'(accept[k]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_en_q <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                count_q[k] <= '0;
                for (int i = 0; i < els_p; i++) begin
                    slot_q[k][i] <= '0;
                end
            end
        end else begin
            ready_en_q <= 1'b1;
            for (int k = 0; k < 2; k++) begin
                count_q[k] <= count_d[k];
                for (int i = 0; i < els_p; i++) begin
                    if (accept[k] && (wr_idx[k] == lg_els_lp'(i))) begin
                        slot_q[k][i] <= lane_data[k];
                    end
                end
            end
        end
    end

    always_comb begin
        data0_o = '0;
        data1_o = '0;
        for (int i = 0; i < els_p; i++) begin
            data0_o[i*width_p +: width_p] = slot_q[0][i];
            data1_o[i*width_p +: width_p] = slot_q[1][i];
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !v_o))
                else $warning("bsg_gear_collector: yumi_i while v_o=0 is ignored");
            assert ((count_q[0] <= els_lp) && (count_q[1] <= els_lp))
                else $error("bsg_gear_collector: lane counter exceeded els_p");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_gear_collector.sv
// Randomized bench for bsg_gear_collector against a queue-based model of the two lanes.
// Build with BSG_GEAR_COLLECTOR_FLOWTHRU_EN defined to exercise the flow-through variant.

module tb_bsg_gear_collector;

  localparam int W = 8;
  localparam int E = 4;
`ifdef BSG_GEAR_COLLECTOR_FLOWTHRU_EN
  localparam bit FLOW = 1'b1;
`else
  localparam bit FLOW = 1'b0;
`endif
  localparam int PERIOD = FLOW ? E : E + 1;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic             v0_i, v1_i, yumi_i;
  logic [W-1:0]     data0_i, data1_i;
  logic             ready0_o, ready1_o, v_o;
  logic [W*E-1:0]   data0_o, data1_o;

  bsg_gear_collector #(.width_p(W), .els_p(E)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v0_i      (v0_i),
    .data0_i   (data0_i),
    .ready0_o  (ready0_o),
    .v1_i      (v1_i),
    .data1_i   (data1_i),
    .ready1_o  (ready1_o),
    .v_o       (v_o),
    .data0_o   (data0_o),
    .data1_o   (data1_o),
    .yumi_i    (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  bit started   = 1'b0;
  bit last_acc0 = 1'b0;
  bit last_acc1 = 1'b0;
  bit last_v    = 1'b0;
  int rise_cyc[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [W*E-1:0] pack_lane(input int lane);
    logic [W*E-1:0] w;
    w = '0;
    for (int i = 0; i < E; i++) w[i*W +: W] = (lane == 0) ? exp_q0[i] : exp_q1[i];
    return w;
  endfunction

  function automatic bit model_v();
    return started && (exp_q0.size() >= E) && (exp_q1.size() >= E);
  endfunction

  // Called at a negedge; drives one cycle, checks outputs, advances the model, returns at next negedge.
  task automatic step(input bit v0, input logic [W-1:0] d0, input bit v1,
                      input logic [W-1:0] d1, input bit y);
    bit mv, fire, mr0, mr1;
    v0_i = v0; data0_i = d0; v1_i = v1; data1_i = d1; yumi_i = y;
    #1;
    mv   = model_v();
    fire = y && mv;
    mr0  = started && ((exp_q0.size() < E) || (FLOW && fire));
    mr1  = started && ((exp_q1.size() < E) || (FLOW && fire));
    check_eq("ready0", ready0_o, mr0);
    check_eq("ready1", ready1_o, mr1);
    check_eq("v_o", v_o, mv);
    if (mv) begin
      check_eq("data0_word", data0_o, pack_lane(0));
      check_eq("data1_word", data1_o, pack_lane(1));
    end
    last_acc0 = v0 && mr0;
    last_acc1 = v1 && mr1;
    if (last_acc0) exp_q0.push_back(d0);
    if (last_acc1) exp_q1.push_back(d1);
    if (fire) begin
      repeat (E) begin
        void'(exp_q0.pop_front());
        void'(exp_q1.pop_front());
      end
    end
    if (mv && !last_v) rise_cyc.push_back(cyc);
    last_v = mv;
    @(posedge clk_i);
    if (reset_n_i) started = 1'b1;
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic async_reset();
    #2;
    reset_n_i = 1'b0;
    v0_i = 1'b0; v1_i = 1'b0; yumi_i = 1'b0;
    #1;
    check_eq("rst_ready0", ready0_o, 1'b0);
    check_eq("rst_ready1", ready1_o, 1'b0);
    check_eq("rst_v_o", v_o, 1'b0);
    check_eq("rst_data0", data0_o, '0);
    check_eq("rst_data1", data1_o, '0);
    exp_q0.delete();
    exp_q1.delete();
    started = 1'b0;
    last_v  = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bit             pv0, pv1, y;
    logic [W-1:0]   pd0, pd1;
    int             n;

    // ---------------- reset / idle ----------------
    reset_n_i = 1'b0;
    v0_i = 1'b0; v1_i = 1'b0; yumi_i = 1'b0; data0_i = '0; data1_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("inrst_ready0", ready0_o, 1'b0);
    check_eq("inrst_v_o", v_o, 1'b0);
    reset_n_i = 1'b1;
    step(0, '0, 0, '0, 0);
    check_eq("post_rst_ready0", ready0_o, 1'b1);
    check_eq("post_rst_ready1", ready1_o, 1'b1);
    check_eq("post_rst_v_o", v_o, 1'b0);
    check_eq("post_rst_data0", data0_o, '0);
    check_eq("post_rst_data1", data1_o, '0);

    // ---------------- basic fill ----------------
    for (int i = 0; i < E; i++) step(1, W'(8'h0A + 2*i), 1, W'(8'h0B + 2*i), 0);
    check_eq("basic_v_o", v_o, 1'b1);
    check_eq("basic_data0", data0_o, 32'h100E0C0A);
    check_eq("basic_data1", data1_o, 32'h110F0D0B);
    check_eq("basic_comb", {data1_o[15:8], data0_o[15:8], data1_o[7:0], data0_o[7:0]}, 32'h0D0C0B0A);
    step(0, '0, 0, '0, 1);
    check_eq("basic_drained", v_o, 1'b0);

    // ---------------- skew / back-pressure ----------------
    for (int i = 0; i < E; i++) step(1, W'(8'h20 + i), 0, '0, 0);
    step(1, 8'h55, 0, '0, 0);
    check_eq("skew_ready0_held", ready0_o, 1'b0);
    for (int i = 0; i < E; i++) step(1, 8'h55, 1, W'(8'h30 + i), 0);
    check_eq("skew_v_o", v_o, 1'b1);
    n = 0;
    step(1, 8'h55, 0, '0, 1);
    n++;
    while (!last_acc0 && n < 5) begin
      step(1, 8'h55, 0, '0, 0);
      n++;
    end
    check_eq("skew_accept_delay", n, FLOW ? 1 : 2);
    check_eq("skew_slot0", data0_o[W-1:0], 8'h55);

    // ---------------- back-to-back ----------------
    rise_cyc.delete();
    pd0 = 8'h40; pd1 = 8'h80;
    for (int i = 0; i < 60 && rise_cyc.size() < 5; i++) begin
      step(1, pd0, 1, pd1, model_v());
      if (last_acc0) pd0 = pd0 + 1'b1;
      if (last_acc1) pd1 = pd1 + 1'b1;
    end
    check_eq("b2b_enough_words", rise_cyc.size() >= 5, 1'b1);
    if (rise_cyc.size() >= 5) begin
      for (int k = 2; k < 5; k++) check_eq("b2b_period", rise_cyc[k] - rise_cyc[k-1], PERIOD);
    end
    step(0, '0, 0, '0, 0);

    // ---------------- reset mid-operation ----------------
    async_reset();
    step(0, '0, 0, '0, 0);
    for (int i = 0; i < 2; i++) step(1, W'(8'hE0 + i), 1, W'(8'hF0 + i), 0);
    async_reset();
    step(0, '0, 0, '0, 0);
    for (int i = 0; i < E; i++) step(1, W'(8'h60 + i), 1, W'(8'h70 + i), 0);
    check_eq("midrst_data0", data0_o, 32'h63626160);
    check_eq("midrst_data1", data1_o, 32'h73727170);
    step(0, '0, 0, '0, 1);

    // ---------------- illegal yumi ----------------
    step(1, 8'h11, 1, 8'h21, 0);
    step(0, '0, 0, '0, 1);
    for (int i = 1; i < E; i++) step(1, W'(8'h11 + i), 1, W'(8'h21 + i), 0);
    check_eq("illegal_yumi_v_o", v_o, 1'b1);
    check_eq("illegal_yumi_data0", data0_o, 32'h14131211);
    step(0, '0, 0, '0, 1);

    // ---------------- randomized traffic ----------------
    pv0 = 1'b0; pv1 = 1'b0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        async_reset();
        pv0 = 1'b0; pv1 = 1'b0;
        continue;
      end
      if (!pv0) begin
        pv0 = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 70 : 25));
        pd0 = W'($urandom);
      end
      if (!pv1) begin
        pv1 = ($urandom_range(0, 99) < 60);
        pd1 = W'($urandom);
      end
      y = model_v() && ($urandom_range(0, 99) < 65);
      step(pv0, pd0, pv1, pd1, y);
      if (last_acc0) pv0 = 1'b0;
      if (last_acc1) pv1 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
